// File: rtl/rwave_peak_scan.sv
// Read sequencer for the multi-lead R-wave buffer with per-lead signed peak search.
// One lane per lead keeps a running max and its address; results are published on the done cycle.

module rwave_peak_lane #(
  parameter int DATA_W = 16,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              cap,
  input  logic [DATA_W-1:0] sample,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] max_nxt,
  output logic [AW-1:0]     idx_nxt
);
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] max_q;
  logic [AW-1:0]     idx_q;

  // Strict compare keeps the earliest address on ties.
  always_comb begin
    max_nxt = max_q;
    idx_nxt = idx_q;
    if (init) begin
      max_nxt = SMIN;
      idx_nxt = '0;
    end else if (cap && ($signed(sample) > $signed(max_q))) begin
      max_nxt = sample;
      idx_nxt = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= SMIN;
      idx_q <= '0;
    end else begin
      max_q <= max_nxt;
      idx_q <= idx_nxt;
    end
  end
endmodule

module rwave_peak_scan #(
  parameter int DATA_W          = 16,
  parameter int NUM_OF_MEM      = 8,
  parameter int LOG2_NUM_OF_MEM = 3,
  parameter int MEM_DEPTH       = 128,
  parameter int LOG2_MEM_DEPTH  = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [LOG2_MEM_DEPTH:0]              len,
  input  logic signed [DATA_W-1:0]             thresh,
  output logic                                 rd_en,
  output logic [LOG2_MEM_DEPTH-1:0]            rd_addr,
  input  logic signed [DATA_W-1:0]             rd_data,
  input  logic                                 rd_inc,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_OF_MEM*DATA_W-1:0]         peak_val,
  output logic [NUM_OF_MEM*LOG2_MEM_DEPTH-1:0] peak_idx,
  output logic [NUM_OF_MEM-1:0]                peak_found,
  output logic                                 sync_err
);
  localparam int LW = LOG2_MEM_DEPTH + 1;
  localparam int CW = LW + LOG2_NUM_OF_MEM;
  localparam logic [LW-1:0]     DEPTH_L = LW'(MEM_DEPTH);
  localparam logic [DATA_W-1:0] SMIN    = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_nxt;

  logic                    start_acc;
  logic [LW-1:0]           len_c;
  logic [CW-1:0]           total_q;   // NUM_OF_MEM * L
  logic [CW-1:0]           iss_q;     // r-1 while scanning
  logic [CW-2:0]           cap_q;     // r-2: lead/address of the sample on rd_data
  logic                    cap_vld;
  logic                    rinc_exp;
  logic signed [DATA_W-1:0] thr_q, thr_nxt;

  logic [NUM_OF_MEM-1:0][DATA_W-1:0]         max_nxt, pv_q;
  logic [NUM_OF_MEM-1:0][LOG2_MEM_DEPTH-1:0] idx_nxt, pi_q;
  logic [NUM_OF_MEM-1:0]                     found_nxt;

  assign len_c    = (len > DEPTH_L) ? DEPTH_L : len;
  assign thr_nxt  = start_acc ? thresh : thr_q;
  assign rd_addr  = iss_q[LOG2_NUM_OF_MEM +: LOG2_MEM_DEPTH];
  assign rinc_exp = (iss_q[LOG2_NUM_OF_MEM-1:0] == '1) && (iss_q < total_q);
  assign peak_val = pv_q;
  assign peak_idx = pi_q;

  always_comb begin
    state_nxt = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        start_acc = 1'b1;
        state_nxt = (len_c == '0) ? DONE : SCAN;
      end
      SCAN:    if (iss_q == total_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      rd_en    <= 1'b0;
      done     <= 1'b0;
      iss_q    <= '0;
      cap_q    <= '0;
      cap_vld  <= 1'b0;
      total_q  <= '0;
      thr_q    <= '0;
      sync_err <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= (state_nxt == SCAN);
      rd_en   <= (state_nxt == SCAN);
      done    <= (state_nxt == DONE);
      iss_q   <= (state_q == SCAN && state_nxt == SCAN) ? iss_q + 1'b1 : '0;
      cap_q   <= iss_q[CW-2:0];
      // The trailing read at r = 8L+1 is a discard; its data never gets captured.
      cap_vld <= (state_q == SCAN) && (iss_q != total_q);
      thr_q   <= thr_nxt;
      if (start_acc) total_q <= {len_c, {LOG2_NUM_OF_MEM{1'b0}}};
      if (start_acc) sync_err <= 1'b0;
      else if (state_q == SCAN && rd_inc != rinc_exp) sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= {NUM_OF_MEM{SMIN}};
      pi_q <= '0;
      peak_found <= '0;
    end else if (state_nxt == DONE) begin
      pv_q <= max_nxt;
      pi_q <= idx_nxt;
      peak_found <= found_nxt;
    end
  end

  for (genvar n = 0; n < NUM_OF_MEM; n++) begin : g_lane
    rwave_peak_lane #(.DATA_W(DATA_W), .AW(LOG2_MEM_DEPTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .init    (start_acc),
      .cap     (cap_vld && (cap_q[LOG2_NUM_OF_MEM-1:0] == LOG2_NUM_OF_MEM'(n))),
      .sample  (rd_data),
      .addr    (cap_q[LOG2_NUM_OF_MEM +: LOG2_MEM_DEPTH]),
      .max_nxt (max_nxt[n]),
      .idx_nxt (idx_nxt[n])
    );
    assign found_nxt[n] = $signed(max_nxt[n]) > thr_nxt;
  end
endmodule
